// File: rtl/crc_pkg.sv
// Shared CRC types, bit-reversal helpers and standard presets for crc_stream_engine.
// Purely declarative: no latency, no flow control.
package crc_pkg;

  typedef logic [31:0] crc_t;

  typedef struct packed {
    logic [5:0] width;
    crc_t       poly;
    crc_t       init;
    crc_t       xor_out;
    logic       refl_in;
    logic       refl_out;
    crc_t       residue;
  } crc_cfg_t;

  localparam crc_cfg_t CRC32_ETH = '{
    width: 6'd32, poly: 32'h04C11DB7, init: 32'hFFFFFFFF, xor_out: 32'hFFFFFFFF,
    refl_in: 1'b1, refl_out: 1'b1, residue: 32'hDEBB20E3
  };

  localparam crc_cfg_t CRC16_CCITT = '{
    width: 6'd16, poly: 32'h00001021, init: 32'h0000FFFF, xor_out: 32'h00000000,
    refl_in: 1'b0, refl_out: 1'b0, residue: 32'h00000000
  };

  localparam crc_cfg_t CRC8_SMBUS = '{
    width: 6'd8, poly: 32'h00000007, init: 32'h00000000, xor_out: 32'h00000000,
    refl_in: 1'b0, refl_out: 1'b0, residue: 32'h00000000
  };

  function automatic logic [7:0] reflect8(input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Reverse the low w bits of v; bits above w come back as zero.
  function automatic crc_t reflect_n(input crc_t v, input int w);
    crc_t r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r >> (32 - w);
  endfunction

endpackage

// File: rtl/crc_byte_step.sv
// Combinational one-byte LFSR update; a disabled step passes the register through.
// Zero latency, no flow control.
module crc_byte_step
  import crc_pkg::*;
#(
  parameter int   CRC_W      = 32,
  parameter crc_t POLY       = CRC32_ETH.poly,
  parameter bit   REFLECT_IN = 1'b1
) (
  input  logic [CRC_W-1:0] crc_i,
  input  logic [7:0]       byte_i,
  input  logic             en_i,
  output logic [CRC_W-1:0] crc_o
);

  localparam logic [CRC_W-1:0] POLY_W = POLY[CRC_W-1:0];

  logic [7:0]       d;
  logic [CRC_W-1:0] r;
  logic             fb;

  always_comb begin
    d  = REFLECT_IN ? reflect8(byte_i) : byte_i;
    r  = crc_i;
    fb = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      fb = r[CRC_W-1] ^ d[i];
      r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY_W : '0);
    end
    crc_o = en_i ? r : crc_i;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker folding DATA_W/8 bytes per beat; result 1 clk after last beat.
// One-deep result buffer: s_ready drops only while a result is held with m_ready low.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int   CRC_W       = 32,
  parameter crc_t POLY        = CRC32_ETH.poly,
  parameter crc_t INIT        = CRC32_ETH.init,
  parameter crc_t XOR_OUT     = CRC32_ETH.xor_out,
  parameter bit   REFLECT_IN  = 1'b1,
  parameter bit   REFLECT_OUT = 1'b1,
  parameter crc_t RESIDUE     = CRC32_ETH.residue,
  parameter int   DATA_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  input  logic [DATA_W/8-1:0] s_keep,
  input  logic                s_last,
  input  logic                s_abort,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [CRC_W-1:0]    m_crc,
  output logic                m_match
);

  localparam int NB = DATA_W / 8;
  localparam logic [CRC_W-1:0] INIT_W = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOR_W  = XOR_OUT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] RES_W  = RESIDUE[CRC_W-1:0];

  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] m_crc_q, m_crc_d;
  logic             m_valid_q, m_valid_d;
  logic             m_match_q, m_match_d;

  logic [CRC_W-1:0] chain [NB+1];
  logic             beat_acc;
  logic             frame_end;
  crc_t             fin_full;
  logic [CRC_W-1:0] fin;

  assign chain[0] = crc_q;

  for (genvar g = 0; g < NB; g++) begin : g_step
    crc_byte_step #(
      .CRC_W      (CRC_W),
      .POLY       (POLY),
      .REFLECT_IN (REFLECT_IN)
    ) u_step (
      .crc_i  (chain[g]),
      .byte_i (s_data[8*g +: 8]),
      .en_i   (s_keep[g]),
      .crc_o  (chain[g+1])
    );
  end

  assign s_ready   = !m_valid_q || m_ready;
  assign beat_acc  = s_valid && s_ready && !s_abort;
  assign frame_end = beat_acc && s_last;

  // The residue is compared after output reflection, so it matches catalogue residues.
  always_comb begin
    fin_full = '0;
    fin_full[CRC_W-1:0] = chain[NB];
    if (REFLECT_OUT) fin_full = reflect_n(fin_full, CRC_W);
    fin = fin_full[CRC_W-1:0];
  end

  always_comb begin
    crc_d     = crc_q;
    m_valid_d = m_valid_q;
    m_crc_d   = m_crc_q;
    m_match_d = m_match_q;
    if (m_ready) m_valid_d = 1'b0;
    if (s_abort) begin
      crc_d = INIT_W;
    end else if (beat_acc) begin
      crc_d = s_last ? INIT_W : chain[NB];
    end
    if (frame_end) begin
      m_valid_d = 1'b1;
      m_crc_d   = fin ^ XOR_W;
      m_match_d = (fin == RES_W);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q     <= INIT_W;
      m_valid_q <= 1'b0;
      m_crc_q   <= '0;
      m_match_q <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      m_valid_q <= m_valid_d;
      m_crc_q   <= m_crc_d;
      m_match_q <= m_match_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_crc   = m_crc_q;
  assign m_match = m_match_q;

  // Byte enables must be a run of ones starting at byte 0.
  logic [NB:0] keep_inc;
  assign keep_inc = {1'b0, s_keep} + (NB+1)'(1);

  always_ff @(posedge clk) begin
    if (!rst && beat_acc) assert ((keep_inc & {1'b0, s_keep}) == '0);
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: CRC-32 on 32-bit and 8-bit beats, CRC-16/CCITT on 8-bit beats.
module tb_crc_stream_engine;
  import crc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_valid, a_ready, a_last, a_abort, a_mvalid, a_mready, a_match;
  logic [31:0] a_data, a_crc;
  logic [3:0]  a_keep;
  logic        rnd_mode, rnd_rdy, mready_cmd;

  logic        b_valid, b_last, b_abort, bc_mready;
  logic [7:0]  b_data;
  logic [0:0]  b_keep;
  logic        b_ready, b_mvalid, b_match, c_ready, c_mvalid, c_match;
  logic [31:0] b_crc;
  logic [15:0] c_crc;

  assign a_mready = rnd_mode ? rnd_rdy : mready_cmd;

  crc_stream_engine #(.DATA_W(32)) u_a (
    .clk(clk), .rst(rst), .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data),
    .s_keep(a_keep), .s_last(a_last), .s_abort(a_abort), .m_valid(a_mvalid),
    .m_ready(a_mready), .m_crc(a_crc), .m_match(a_match));

  crc_stream_engine #(.DATA_W(8)) u_b (
    .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
    .s_keep(b_keep), .s_last(b_last), .s_abort(b_abort), .m_valid(b_mvalid),
    .m_ready(bc_mready), .m_crc(b_crc), .m_match(b_match));

  crc_stream_engine #(.CRC_W(16), .POLY(32'h1021), .INIT(32'hFFFF), .XOR_OUT(32'h0),
                      .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0), .RESIDUE(32'h0), .DATA_W(8)) u_c (
    .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(c_ready), .s_data(b_data),
    .s_keep(b_keep), .s_last(b_last), .s_abort(b_abort), .m_valid(c_mvalid),
    .m_ready(bc_mready), .m_crc(c_crc), .m_match(c_match));

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef logic [7:0] bq_t[$];

  // Reference: textbook right-shifting CRC-32 with the reversed polynomial.
  function automatic void ref_crc32(input bq_t m, output logic [31:0] crc, output logic match);
    logic [31:0] r;
    r = 32'hFFFFFFFF;
    foreach (m[k]) begin
      r = r ^ {24'h0, m[k]};
      repeat (8) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    crc   = ~r;
    match = (r == 32'hDEBB20E3);
  endfunction

  function automatic bq_t s2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold one beat on A until the engine takes it; returns at edge+1 after acceptance.
  task automatic a_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    n = 0;
    a_valid = 1'b1; a_data = d; a_keep = k; a_last = l;
    #2;
    while (!a_ready && n < 500) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (!a_ready) check("a_beat_timeout", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0; a_last = 1'b0; a_keep = '0;
  endtask

  task automatic a_frame(input bq_t m, input bit rnd_chunk);
    int i;
    int n;
    logic [31:0] d;
    logic [3:0]  k;
    i = 0;
    if (m.size() == 0) begin
      a_beat($urandom, 4'b0000, 1'b1);
      return;
    end
    while (i < m.size()) begin
      n = rnd_chunk ? int'($urandom_range(0, 4)) : 4;
      d = $urandom;
      k = '0;
      for (int j = 0; j < n; j++) begin
        if (i < m.size()) begin
          d[8*j +: 8] = m[i];
          k[j] = 1'b1;
          i++;
        end
      end
      a_beat(d, k, i >= m.size());
    end
  endtask

  task automatic bc_frame(input bq_t m);
    if (m.size() == 0) begin
      b_valid = 1'b1; b_keep = 1'b0; b_last = 1'b1; b_data = 8'($urandom);
      tick();
    end else begin
      foreach (m[k]) begin
        b_valid = 1'b1; b_keep = 1'b1; b_data = m[k]; b_last = (k == m.size() - 1);
        tick();
      end
    end
    b_valid = 1'b0; b_last = 1'b0; b_keep = 1'b0;
  endtask

  // Scoreboard for the randomized phase: {match, crc} per frame in send order.
  logic [32:0] exp_q[$];
  bit mon_en = 1'b0;

  always @(posedge clk) begin
    #2;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (mon_en && a_mvalid && a_mready) begin
      if (exp_q.size() == 0) begin
        check("rnd_unexpected_result", 32'(a_mvalid), 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("rnd_crc", a_crc, e[31:0]);
        check("rnd_match", 32'(a_match), 32'(e[32]));
      end
    end
  end

  typedef struct {
    string       name;
    string       msg;
    int          tail_n;
    logic [31:0] tail;
    logic [31:0] crc;
    logic        match;
    bit          crc_known;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    bq_t  m;
    logic [31:0] e_crc;
    logic        e_m;

    vecs[0] = '{"check9",   "123456789", 0, 32'h0,        32'hCBF43926, 1'b0, 1'b1};
    vecs[1] = '{"single_a", "a",         0, 32'h0,        32'hE8B7BE43, 1'b0, 1'b1};
    vecs[2] = '{"empty",    "",          0, 32'h0,        32'h00000000, 1'b0, 1'b1};
    vecs[3] = '{"codeword", "123456789", 4, 32'hCBF43926, 32'h2144DF1C, 1'b1, 1'b1};
    vecs[4] = '{"flipped",  "123456788", 4, 32'hCBF43926, 32'h0,        1'b0, 1'b0};
    vecs[5] = '{"abc",      "abc",       0, 32'h0,        32'h352441C2, 1'b0, 1'b1};

    rst = 1'b1;
    a_valid = 0; a_last = 0; a_abort = 0; a_data = 0; a_keep = 0;
    rnd_mode = 0; mready_cmd = 1;
    b_valid = 0; b_last = 0; b_abort = 0; b_data = 0; b_keep = 0; bc_mready = 1;
    tick(); tick();
    rst = 1'b0;

    check("reset_m_valid", 32'(a_mvalid), 32'd0);
    check("reset_m_crc",   a_crc,         32'd0);
    check("reset_m_match", 32'(a_match),  32'd0);
    check("reset_s_ready", 32'(a_ready),  32'd1);

    // Table-driven frames on 32-bit beats, contiguous keeps.
    foreach (vecs[v]) begin
      m = s2q(vecs[v].msg);
      for (int t = 0; t < vecs[v].tail_n; t++) m.push_back(vecs[v].tail[8*t +: 8]);
      ref_crc32(m, e_crc, e_m);
      a_frame(m, 1'b0);
      check({vecs[v].name, "_valid"}, 32'(a_mvalid), 32'd1);
      check({vecs[v].name, "_crc"},   a_crc, vecs[v].crc_known ? vecs[v].crc : e_crc);
      check({vecs[v].name, "_match"}, 32'(a_match), 32'(vecs[v].match));
      tick();
    end

    // Byte-per-beat CRC-32 and CRC-16/CCITT together.
    check("b_idle_valid", 32'(b_mvalid), 32'd0);
    bc_frame(s2q("123456789"));
    check("b_valid_after_last", 32'(b_mvalid), 32'd1);
    check("b_crc32_check9", b_crc, 32'hCBF43926);
    check("c_crc16_check9", 32'(c_crc), 32'h29B1);
    check("c_match_check9", 32'(c_match), 32'd0);
    tick();
    check("b_valid_cleared", 32'(b_mvalid), 32'd0);
    m.delete();
    bc_frame(m);
    check("b_empty_crc", b_crc, 32'h0);
    check("c_empty_crc", 32'(c_crc), 32'hFFFF);
    tick();

    // Result held under backpressure, then consumed in the same cycle a new last beat lands.
    mready_cmd = 1'b0;
    a_frame(s2q("a"), 1'b0);
    check("bp_valid", 32'(a_mvalid), 32'd1);
    check("bp_crc", a_crc, 32'hE8B7BE43);
    check("bp_s_ready_low", 32'(a_ready), 32'd0);
    a_valid = 1'b1; a_data = 32'h34333231; a_keep = 4'hF; a_last = 1'b1;
    tick(); tick();
    check("bp_hold_valid", 32'(a_mvalid), 32'd1);
    check("bp_hold_crc", a_crc, 32'hE8B7BE43);
    mready_cmd = 1'b1;
    tick();
    a_valid = 1'b0; a_last = 1'b0; a_keep = '0;
    ref_crc32(s2q("1234"), e_crc, e_m);
    check("bp_b_valid", 32'(a_mvalid), 32'd1);
    check("bp_b_crc", a_crc, e_crc);
    tick();
    check("bp_b_consumed", 32'(a_mvalid), 32'd0);

    // Reset mid-frame after 5 bytes.
    a_beat(32'h34333231, 4'hF, 1'b0);
    a_beat(32'hAABBCC35, 4'h1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", 32'(a_mvalid), 32'd0);
    check("midrst_crc", a_crc, 32'd0);
    check("midrst_ready", 32'(a_ready), 32'd1);
    a_frame(s2q("123456789"), 1'b0);
    check("after_rst_crc", a_crc, 32'hCBF43926);
    tick();

    // Abort mid-frame; the concurrent last beat must be dropped.
    a_beat(32'h34333231, 4'hF, 1'b0);
    a_beat(32'h00000035, 4'h1, 1'b0);
    a_valid = 1'b1; a_data = $urandom; a_keep = 4'hF; a_last = 1'b1; a_abort = 1'b1;
    tick();
    a_valid = 1'b0; a_last = 1'b0; a_abort = 1'b0; a_keep = '0;
    check("abort_drops_beat", 32'(a_mvalid), 32'd0);
    a_frame(s2q("123456789"), 1'b0);
    check("after_abort_crc", a_crc, 32'hCBF43926);
    tick();

    // Abort leaves a pending result untouched.
    mready_cmd = 1'b0;
    a_frame(s2q("a"), 1'b0);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    check("abort_keeps_valid", 32'(a_mvalid), 32'd1);
    check("abort_keeps_crc", a_crc, 32'hE8B7BE43);
    mready_cmd = 1'b1;
    tick();

    // Random frames, random chunking (including empty beats), random m_ready.
    rnd_mode = 1'b1;
    mon_en   = 1'b1;
    for (int f = 0; f < 60; f++) begin
      int len;
      m.delete();
      len = $urandom_range(0, 20);
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      if (f % 7 == 3) begin
        ref_crc32(m, e_crc, e_m);
        for (int t = 0; t < 4; t++) m.push_back(e_crc[8*t +: 8]);
      end
      ref_crc32(m, e_crc, e_m);
      exp_q.push_back({e_m, e_crc});
      a_frame(m, 1'b1);
    end
    rnd_mode = 1'b0;
    repeat (5) tick();
    mon_en = 1'b0;
    check("rnd_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
